// File: rtl/sweeper_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sweeper_pkg : shared types and constants for the evolved-circuit sweeper
// Rev 1.0
// ---------------------------------------------------------------------------
package sweeper_pkg;

  localparam int VEC_W             = 5;
  localparam int NUM_VEC           = 32;
  localparam int DEF_SETTLE_CYCLES = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic logic [VEC_W-1:0] bin2gray(input logic [VEC_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/evolved_circuit_sweeper_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// evolved_circuit_sweeper_if : control, stimulus and result signals of the sweeper
// Rev 1.0
// ---------------------------------------------------------------------------
interface evolved_circuit_sweeper_if;
  import sweeper_pkg::*;

  logic                 start;
  logic [VEC_W-1:0]     sel_in;
  logic [NUM_VEC-1:0]   expected;
  logic                 resp_in;
  logic [2*VEC_W-1:0]   stim;
  logic                 busy;
  logic                 done;
  logic [NUM_VEC-1:0]   truth;
  logic                 pass;

  modport master (
    output start, sel_in, expected, resp_in,
    input  stim, busy, done, truth, pass
  );

  modport slave (
    input  start, sel_in, expected, resp_in,
    output stim, busy, done, truth, pass
  );

endinterface
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync2 : two-flop synchroniser with asynchronous active-low clear
// Rev 1.0
// ---------------------------------------------------------------------------
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/evolved_circuit_sweeper.sv
`default_nettype none
// ---------------------------------------------------------------------------
// evolved_circuit_sweeper : drives all 32 input vectors onto the shared stimulus
// bus and captures the selected circuit's response as a truth table.  Rev 1.0
// ---------------------------------------------------------------------------
module evolved_circuit_sweeper
  import sweeper_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter bit GRAY_ORDER    = 1'b0
) (
  input  logic                    CLOCK_50,
  input  logic                    reset_n,
  evolved_circuit_sweeper_if.slave bus
);

  localparam int               CNT_W    = $clog2(SETTLE_CYCLES + 3);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES + 1);
  localparam logic [VEC_W-1:0] IDX_LAST = VEC_W'(NUM_VEC - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [VEC_W-1:0]     idx_q, idx_d;
  logic [2*VEC_W-1:0]   stim_q, stim_d;
  logic [NUM_VEC-1:0]   truth_q, truth_d;
  logic                 pass_q, pass_d;
  logic                 resp_sync;
  logic [VEC_W-1:0]     idx_nxt;

  function automatic logic [VEC_W-1:0] vec_of(input logic [VEC_W-1:0] k);
    return GRAY_ORDER ? bin2gray(k) : k;
  endfunction

  sync2 u_resp_sync (
    .clk   (CLOCK_50),
    .rst_n (reset_n),
    .d     (bus.resp_in),
    .q     (resp_sync)
  );

  assign idx_nxt = idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stim_d  = stim_q;
    truth_d = truth_q;
    pass_d  = pass_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          stim_d  = {bus.sel_in, vec_of('0)};
          idx_d   = '0;
          cnt_d   = '0;
          truth_d = '0;
          pass_d  = 1'b0;
          state_d = ST_WAIT;
        end
      end
      // Settle time plus two cycles for the response to cross the synchroniser
      ST_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        truth_d[vec_of(idx_q)] = resp_sync;
        if (idx_q == IDX_LAST) begin
          pass_d  = (truth_d == bus.expected);
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_nxt;
          stim_d  = {stim_q[2*VEC_W-1:VEC_W], vec_of(idx_nxt)};
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      stim_q  <= '0;
      truth_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stim_q  <= stim_d;
      truth_q <= truth_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.stim  = stim_q;
  assign bus.truth = truth_q;
  assign bus.pass  = pass_q;
  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.done  = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_evolved_circuit_sweeper.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_evolved_circuit_sweeper : scoreboard bench for binary- and Gray-order sweepers
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_evolved_circuit_sweeper;

  localparam int SETTLE = 4;
  localparam int P      = SETTLE + 3;
  localparam int SWEEP  = 32 * P;

  typedef struct {
    logic [31:0] truth;
    logic        pass;
    logic [4:0]  sel;
    int          acc;
  } exp_t;

  logic CLOCK_50 = 1'b0;
  logic reset_n  = 1'b0;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  exp_t q_b[$];
  exp_t q_g[$];
  int   mode_b = 0;
  int   mode_g = 0;
  int   seq_err [2];
  logic post    [2];
  logic [4:0] rec [2][32];
  logic [9:0] dly_b, dly_g;

  evolved_circuit_sweeper_if if_b ();
  evolved_circuit_sweeper_if if_g ();

  evolved_circuit_sweeper #(.SETTLE_CYCLES(SETTLE), .GRAY_ORDER(1'b0)) u_bin (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .bus      (if_b.slave)
  );

  evolved_circuit_sweeper #(.SETTLE_CYCLES(SETTLE), .GRAY_ORDER(1'b1)) u_gray (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .bus      (if_g.slave)
  );

  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Circuit stubs: 0 = XOR of bits 0/1, 1 = constant one, 2 = XOR lagging stim by a cycle
  always @(posedge CLOCK_50) begin
    dly_b <= if_b.stim;
    dly_g <= if_g.stim;
  end

  function automatic logic stub(input int mode, input logic [9:0] s, input logic [9:0] d);
    case (mode)
      1:       return 1'b1;
      2:       return d[0] ^ d[1];
      default: return s[0] ^ s[1];
    endcase
  endfunction

  assign if_b.resp_in = stub(mode_b, if_b.stim, dly_b);
  assign if_g.resp_in = stub(mode_g, if_g.stim, dly_g);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor step for one DUT: tracks the stimulus sequence and scores completed sweeps
  task automatic on_cycle(input int id);
    logic        d, b, p, have;
    logic [31:0] t;
    logic [9:0]  s;
    logic [4:0]  k, v;
    exp_t        e;
    int          el, bad;
    string       tag;
    int          gray8 [8];
    gray8 = '{0, 1, 3, 2, 6, 7, 5, 4};
    tag  = (id == 0) ? "bin" : "gray";
    d    = (id == 0) ? if_b.done  : if_g.done;
    b    = (id == 0) ? if_b.busy  : if_g.busy;
    p    = (id == 0) ? if_b.pass  : if_g.pass;
    t    = (id == 0) ? if_b.truth : if_g.truth;
    s    = (id == 0) ? if_b.stim  : if_g.stim;
    have = (id == 0) ? (q_b.size() != 0) : (q_g.size() != 0);
    if (have) e = (id == 0) ? q_b[0] : q_g[0];

    if (post[id]) begin
      post[id] = 1'b0;
      check($sformatf("%s_done_pulse_end", tag), {62'd0, d, b}, 64'd0);
    end

    if (reset_n && b && !d && have) begin
      el = cyc - e.acc;
      if (el >= 0 && el < SWEEP) begin
        k = 5'(el / P);
        v = (id == 1) ? (k ^ (k >> 1)) : k;
        if (s !== {e.sel, v}) seq_err[id]++;
        if (el % P == 0) rec[id][k] = s[4:0];
      end
    end

    if (reset_n && d) begin
      if (!have) begin
        check($sformatf("%s_unexpected_done", tag), 64'd1, 64'd0);
      end else begin
        if (id == 0) void'(q_b.pop_front());
        else         void'(q_g.pop_front());
        check($sformatf("%s_truth", tag), t, e.truth);
        check($sformatf("%s_pass", tag), p, e.pass);
        check($sformatf("%s_done_cycle", tag), cyc, e.acc + SWEEP);
        check($sformatf("%s_sel_held", tag), s[9:5], e.sel);
        check($sformatf("%s_stim_seq_errors", tag), seq_err[id], 0);
        if (id == 1) begin
          bad = 0;
          for (int i = 0; i < 8; i++) if (rec[1][i] != 5'(gray8[i])) bad++;
          check("gray_first8_order", bad, 0);
        end
        seq_err[id] = 0;
        post[id]    = 1'b1;
      end
    end
  endtask

  initial begin
    seq_err[0] = 0; seq_err[1] = 0;
    post[0] = 1'b0; post[1] = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      on_cycle(0);
      on_cycle(1);
    end
  end

  task automatic start_sweep(input int id, input logic [4:0] sel, input logic [31:0] expv,
                             input int mode, input logic [31:0] t_exp, input logic p_exp);
    exp_t e;
    @(negedge CLOCK_50);
    e.truth = t_exp;
    e.pass  = p_exp;
    e.sel   = sel;
    e.acc   = cyc + 1;
    if (id == 0) begin
      mode_b = mode; if_b.sel_in = sel; if_b.expected = expv; if_b.start = 1'b1;
      q_b.push_back(e);
    end else begin
      mode_g = mode; if_g.sel_in = sel; if_g.expected = expv; if_g.start = 1'b1;
      q_g.push_back(e);
    end
    @(negedge CLOCK_50);
    if (id == 0) if_b.start = 1'b0;
    else         if_g.start = 1'b0;
    check($sformatf("%s_busy_after_start", (id == 0) ? "bin" : "gray"),
          (id == 0) ? if_b.busy : if_g.busy, 64'd1);
  endtask

  task automatic wait_idle(input int id);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < SWEEP + 40 && !ok; n++) begin
      @(negedge CLOCK_50);
      ok = (id == 0) ? (!if_b.busy && q_b.size() == 0) : (!if_g.busy && q_g.size() == 0);
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: sweep not finished after %0d cycles", (id == 0) ? "bin" : "gray", SWEEP + 40);
      if (id == 0) q_b.delete();
      else         q_g.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    if_b.start = 1'b0; if_b.sel_in = '0; if_b.expected = '0;
    if_g.start = 1'b0; if_g.sel_in = '0; if_g.expected = '0;
    repeat (3) @(negedge CLOCK_50);
    check("reset_stim",  if_b.stim,  64'd0);
    check("reset_truth", if_b.truth, 64'd0);
    check("reset_flags", {if_b.busy, if_b.done, if_b.pass}, 64'd0);
    reset_n = 1'b1;
    @(negedge CLOCK_50);
    check("idle_after_reset", {if_b.busy, if_g.busy, if_b.done, if_g.done}, 64'd0);

    // XOR circuit on select 5
    start_sweep(0, 5'd5, 32'h6666_6666, 0, 32'h6666_6666, 1'b1);
    wait_idle(0);

    // Constant-one circuit: mismatching expected table, results must hold afterwards
    start_sweep(0, 5'd26, 32'h0000_FFFF, 1, 32'hFFFF_FFFF, 1'b0);
    wait_idle(0);
    repeat (20) @(negedge CLOCK_50);
    check("hold_truth", if_b.truth, 64'hFFFF_FFFF);
    check("hold_pass",  if_b.pass,  64'd0);
    check("hold_stim",  if_b.stim,  {54'd0, 5'd26, 5'd31});

    // Gray-order sweep of the XOR circuit
    start_sweep(1, 5'd3, 32'h6666_6666, 0, 32'h6666_6666, 1'b1);
    wait_idle(1);

    // start pulse and select change mid-sweep must be ignored
    start_sweep(0, 5'd5, 32'h6666_6666, 0, 32'h6666_6666, 1'b1);
    repeat (50) @(negedge CLOCK_50);
    if_b.start = 1'b1; if_b.sel_in = 5'd9;
    @(negedge CLOCK_50);
    if_b.start = 1'b0;
    wait_idle(0);

    // Circuit whose output lags its input by one cycle
    start_sweep(0, 5'd12, 32'h6666_6666, 2, 32'h6666_6666, 1'b1);
    wait_idle(0);

    // Asynchronous reset at cycle 100 of a sweep, then a clean restart
    start_sweep(0, 5'd7, 32'h6666_6666, 0, 32'h6666_6666, 1'b1);
    repeat (100) @(negedge CLOCK_50);
    check("pre_reset_busy", if_b.busy, 64'd1);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset_stim",  if_b.stim,  64'd0);
    check("async_reset_truth", if_b.truth, 64'd0);
    check("async_reset_flags", {if_b.busy, if_b.done, if_b.pass}, 64'd0);
    check("async_reset_gray_truth", if_g.truth, 64'd0);
    q_b.delete();
    seq_err[0] = 0;
    repeat (3) @(negedge CLOCK_50);
    reset_n = 1'b1;
    start_sweep(0, 5'd7, 32'h6666_6666, 0, 32'h6666_6666, 1'b1);
    wait_idle(0);

    repeat (5) @(negedge CLOCK_50);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/evolved_circuit_sweeper.md
# evolved_circuit_sweeper

Automatic stimulus driver and response capture for the evolved-circuit test harness. It replaces manual switch toggling: it latches a circuit select, drives every input vector onto the stimulus bus shared by all circuits under test, and samples the selected circuit's output bit once per vector. The result is a 32-entry truth table plus a pass flag against an expected table. It sits between the board controls and the circuit bank, on the input side of the existing output-select path.

## Interface
- SETTLE_CYCLES, 4, cycles the stimulus is held before the synchronised response is sampled (≥1)
- GRAY_ORDER, 0, 0 = ascending binary vector order; 1 = reflected-Gray order (one input bit changes per step, for latch/flip-flop circuits)
- CLOCK_50  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  level; accepted only in IDLE
- sel_in  in  5  circuit select, latched on start
- expected  in  32  expected truth table, bit i = response to vector i; sampled at completion
- resp_in  in  1  selected circuit output, asynchronous to CLOCK_50
- stim  out  10  stimulus bus to all circuits: [9:5] latched select, [4:0] current vector
- busy  out  1  high from start acceptance through the DONE cycle
- done  out  1  one-cycle pulse; truth/pass valid from this cycle
- truth  out  32  captured truth table, bit i = response to vector value i
- pass  out  1  truth == expected, updated with done

## Operation
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE: start=1 → sel latched into stim[9:5], step index k←0, stim[4:0]←vec(0), counter←0, busy←1, truth←0, pass←0, go to WAIT.
- WAIT: counter increments each cycle; after SETTLE_CYCLES+2 cycles → SAMPLE. The +2 covers the resp_in two-flop synchroniser.
- SAMPLE: truth[vec(k)] ← synchronised resp_in.
  - If k==31 → DONE.
  - Otherwise k←k+1, stim[4:0]←vec(k+1), counter←0, → WAIT.
- DONE: done=1 and pass ← (truth_final == expected) for one cycle, then busy←0 → IDLE.
- vec(k) = k when GRAY_ORDER=0; k ^ (k>>1) when GRAY_ORDER=1. Indexing truth by vector value makes the table order-independent.
- start while busy: ignored. sel_in changes during a sweep: ignored; stim[9:5] stays fixed.
- After DONE: truth and pass hold until the next accepted start. stim holds its last value.
- Reset (any time, including mid-sweep): state IDLE; stim, truth, pass, busy, done, counter, index and synchroniser flops all 0 immediately. No partial result survives.

## Timing
- Per-vector period P = SETTLE_CYCLES + 3 cycles (WAIT + SAMPLE).
- Start accepted at edge 0 → stim valid after edge 0 → first sample at edge SETTLE_CYCLES+3 → done asserted after edge 32·P. With the default, P = 7 and done follows edge 224.
- stim changes only on SAMPLE edges (and at acceptance), never during WAIT.
- done is high exactly one cycle. busy falls on the edge after done.
- A new start may be accepted in the cycle after busy falls.

## Structure
- Shared package sweeper_pkg holds:
  - state enum
  - VEC_W = 5, NUM_VEC = 32
  - default SETTLE_CYCLES
  - Gray-conversion function
- One sub-module, sync2: two-flop synchroniser with asynchronous active-low clear, used for resp_in.
- Counter width is clog2(SETTLE_CYCLES+3). Index is 5 bits, with the terminal check k==31 (no wrap).

## Test plan
- XOR stub (resp_in = stim[0]^stim[1]), SETTLE_CYCLES=4, sel_in=5, expected=0x66666666, start pulse → stim[9:5]=5 throughout, done pulse after edge 224, truth=0x66666666, pass=1.
- Constant-1 stub, expected=0x0000FFFF → truth=0xFFFFFFFF, pass=0; both hold after busy falls.
- GRAY_ORDER=1 with the XOR stub → stim[4:0] sequence 0,1,3,2,6,7,5,4,… with one bit changing per step; truth=0x66666666.
- Assert reset_n=0 at cycle 100 of a sweep → all outputs 0 without waiting for a clock edge, state IDLE. Restart after release → correct full result.
- Pulse start and change sel_in 5→9 at cycle 50 of a sweep → no restart, stim[9:5] stays 5, done still after edge 224.
- Stub whose response changes 1 cycle after stim → sampled value reflects the new stim (settle plus sync margin respected), truth correct.
